// File: rtl/tb_douta_seq.sv
// TB port-A read sequencer with round-robin arbitration between the A-side
// and M-side loaders. One burst is in flight at a time. The mapper select
// and l_k_0 follow the reads through an RD_LAT-deep pipeline, so each select
// lines up with the data word it describes.
module tb_douta_seq #(
    parameter int TB_AW  = 10,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             a_req,
    input  logic [1:0]       a_dir,
    input  logic [TB_AW-1:0] a_base,
    input  logic [LEN_W-1:0] a_len,
    input  logic             a_lk0,
    output logic             a_gnt,
    output logic             a_done,
    input  logic             m_req,
    input  logic [1:0]       m_dir,
    input  logic [TB_AW-1:0] m_base,
    input  logic [LEN_W-1:0] m_len,
    input  logic             m_lk0,
    output logic             m_gnt,
    output logic             m_done,
    output logic             TB_ena,
    output logic [TB_AW-1:0] TB_addra,
    output logic [2:0]       TB_douta_sel,
    output logic             l_k_0,
    output logic             busy
);

    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               last_m_q, last_m_d;   // 1: M was granted last
    logic               dest_q, dest_d;       // 1: burst belongs to M
    logic [1:0]         dir_q, dir_d;
    logic               lk0_q, lk0_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;         // reads left, including current
    logic [DW-1:0]      drn_q, drn_d;         // drain cycles left minus one
    logic               ena_q, ena_d;
    logic [TB_AW-1:0]   addra_q, addra_d;
    logic               a_gnt_q, a_gnt_d, m_gnt_q, m_gnt_d;
    logic               a_done_q, a_done_d, m_done_q, m_done_d;
    logic               busy_q, busy_d;

    // Select pipeline entry {dest, dir, lk0}; bubbles are stored as zero so
    // the mapper sees 3'b000 and l_k_0 = 0 whenever no word is arriving.
    logic [3:0]         sel_pipe_q [RD_LAT];

    logic               pick_m;
    logic [LEN_W-1:0]   pick_len;

    // Next-state and registered-output logic for the sequencer FSM
    always_comb begin
        state_d  = state_q;
        last_m_d = last_m_q;
        dest_d   = dest_q;
        dir_d    = dir_q;
        lk0_d    = lk0_q;
        cnt_d    = cnt_q;
        drn_d    = drn_q;
        ena_d    = 1'b0;
        addra_d  = addra_q;
        a_gnt_d  = 1'b0;
        m_gnt_d  = 1'b0;
        a_done_d = 1'b0;
        m_done_d = 1'b0;
        pick_m   = 1'b0;
        pick_len = '0;
        case (state_q)
            IDLE: begin
                if (a_req || m_req) begin
                    // Tie goes to whoever was not granted last
                    pick_m   = m_req && (!a_req || !last_m_q);
                    pick_len = pick_m ? m_len : a_len;
                    dest_d   = pick_m;
                    dir_d    = pick_m ? m_dir : a_dir;
                    lk0_d    = pick_m ? m_lk0 : a_lk0;
                    last_m_d = pick_m;
                    a_gnt_d  = !pick_m;
                    m_gnt_d  = pick_m;
                    if (pick_len != '0) begin
                        state_d = ISSUE;
                        ena_d   = 1'b1;
                        addra_d = pick_m ? m_base : a_base;
                        cnt_d   = pick_len;
                    end else begin
                        state_d = DRAIN;
                        drn_d   = DW'(RD_LAT - 1);
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DRAIN;
                    drn_d   = DW'(RD_LAT - 1);
                end else begin
                    ena_d   = 1'b1;
                    addra_d = addra_q + TB_AW'(1);
                    cnt_d   = cnt_q - LEN_W'(1);
                end
            end
            DRAIN: begin
                if (drn_q == '0) begin
                    state_d  = IDLE;
                    a_done_d = !dest_q;
                    m_done_d = dest_q;
                end else begin
                    drn_d = drn_q - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM state and registered outputs; reset drops any in-flight burst
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            last_m_q <= 1'b1;
            dest_q   <= 1'b0;
            dir_q    <= 2'b00;
            lk0_q    <= 1'b0;
            cnt_q    <= '0;
            drn_q    <= '0;
            ena_q    <= 1'b0;
            addra_q  <= '0;
            a_gnt_q  <= 1'b0;
            m_gnt_q  <= 1'b0;
            a_done_q <= 1'b0;
            m_done_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_m_q <= last_m_d;
            dest_q   <= dest_d;
            dir_q    <= dir_d;
            lk0_q    <= lk0_d;
            cnt_q    <= cnt_d;
            drn_q    <= drn_d;
            ena_q    <= ena_d;
            addra_q  <= addra_d;
            a_gnt_q  <= a_gnt_d;
            m_gnt_q  <= m_gnt_d;
            a_done_q <= a_done_d;
            m_done_q <= m_done_d;
            busy_q   <= busy_d;
        end
    end

    // Delay the per-read select by the BRAM latency
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < RD_LAT; i++) sel_pipe_q[i] <= 4'b0000;
        end else begin
            sel_pipe_q[0] <= ena_q ? {dest_q, dir_q, lk0_q} : 4'b0000;
            for (int i = 1; i < RD_LAT; i++) sel_pipe_q[i] <= sel_pipe_q[i-1];
        end
    end

    assign a_gnt        = a_gnt_q;
    assign m_gnt        = m_gnt_q;
    assign a_done       = a_done_q;
    assign m_done       = m_done_q;
    assign TB_ena       = ena_q;
    assign TB_addra     = addra_q;
    assign busy         = busy_q;
    assign TB_douta_sel = sel_pipe_q[RD_LAT-1][3:1];
    assign l_k_0        = sel_pipe_q[RD_LAT-1][0];

endmodule

// File: tb/tb_tb_douta_seq.sv
// Directed bench for tb_douta_seq: dut1 uses RD_LAT = 1, dut2 uses
// RD_LAT = 2 (driven only on its A-side, M-side tied idle).
module tb_tb_douta_seq;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;

    logic       a_req = 1'b0, m_req = 1'b0, a_lk0 = 1'b0, m_lk0 = 1'b0;
    logic [1:0] a_dir = 2'b00, m_dir = 2'b00;
    logic [9:0] a_base = 10'h0, m_base = 10'h0;
    logic [7:0] a_len = 8'h0, m_len = 8'h0;

    logic       b_req = 1'b0, b_lk0 = 1'b0;
    logic [1:0] b_dir = 2'b00;
    logic [9:0] b_base = 10'h0;
    logic [7:0] b_len = 8'h0;

    logic       a_gnt1, a_done1, m_gnt1, m_done1, ena1, lk1, busy1;
    logic [9:0] addr1;
    logic [2:0] sel1;
    logic       a_gnt2, a_done2, m_gnt2, m_done2, ena2, lk2, busy2;
    logic [9:0] addr2;
    logic [2:0] sel2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tb_douta_seq dut1 (
        .clk(clk), .sys_rst(sys_rst),
        .a_req(a_req), .a_dir(a_dir), .a_base(a_base), .a_len(a_len), .a_lk0(a_lk0),
        .a_gnt(a_gnt1), .a_done(a_done1),
        .m_req(m_req), .m_dir(m_dir), .m_base(m_base), .m_len(m_len), .m_lk0(m_lk0),
        .m_gnt(m_gnt1), .m_done(m_done1),
        .TB_ena(ena1), .TB_addra(addr1), .TB_douta_sel(sel1), .l_k_0(lk1), .busy(busy1)
    );

    tb_douta_seq #(.RD_LAT(2)) dut2 (
        .clk(clk), .sys_rst(sys_rst),
        .a_req(b_req), .a_dir(b_dir), .a_base(b_base), .a_len(b_len), .a_lk0(b_lk0),
        .a_gnt(a_gnt2), .a_done(a_done2),
        .m_req(1'b0), .m_dir(2'b00), .m_base(10'h000), .m_len(8'h00), .m_lk0(1'b0),
        .m_gnt(m_gnt2), .m_done(m_done2),
        .TB_ena(ena2), .TB_addra(addr2), .TB_douta_sel(sel2), .l_k_0(lk2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check every output of one DUT; the address only matters while reading
    task automatic cyc(input string tag, input bit d2,
                       input logic eag, input logic emg, input logic ead, input logic emd,
                       input logic ee, input logic [9:0] eaddr, input logic [2:0] esel,
                       input logic elk, input logic eb);
        chk({tag, " a_gnt"},  d2 ? a_gnt2  : a_gnt1,  eag);
        chk({tag, " m_gnt"},  d2 ? m_gnt2  : m_gnt1,  emg);
        chk({tag, " a_done"}, d2 ? a_done2 : a_done1, ead);
        chk({tag, " m_done"}, d2 ? m_done2 : m_done1, emd);
        chk({tag, " ena"},    d2 ? ena2    : ena1,    ee);
        if (ee) chk({tag, " addr"}, d2 ? addr2 : addr1, eaddr);
        chk({tag, " sel"},    d2 ? sel2    : sel1,    esel);
        chk({tag, " lk"},     d2 ? lk2     : lk1,     elk);
        chk({tag, " busy"},   d2 ? busy2   : busy1,   eb);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset state
        step(); step();
        cyc("rst1", 1'b0, 0,0,0,0, 0, 10'h0, 3'b000, 0, 0);
        chk("rst1 addr", addr1, 10'h0);
        cyc("rst2", 1'b1, 0,0,0,0, 0, 10'h0, 3'b000, 0, 0);
        sys_rst = 1'b0;
        idle(2);

        // Tie from reset: A first, M after a_done, then A again
        a_dir = 2'b01; a_base = 10'h020; a_len = 8'd2; a_req = 1'b1;
        m_dir = 2'b10; m_base = 10'h040; m_len = 8'd2; m_req = 1'b1;
        step(); cyc("rr t1", 0, 1,0,0,0, 1, 10'h020, 3'b000, 0, 1); a_req = 1'b0;
        step(); cyc("rr t2", 0, 0,0,0,0, 1, 10'h021, 3'b001, 0, 1);
        step(); cyc("rr t3", 0, 0,0,0,0, 0, 10'h0,   3'b001, 0, 1);
        step(); cyc("rr t4", 0, 0,0,1,0, 0, 10'h0,   3'b000, 0, 0);
        step(); cyc("rr t5", 0, 0,1,0,0, 1, 10'h040, 3'b000, 0, 1); m_req = 1'b0;
        step(); cyc("rr t6", 0, 0,0,0,0, 1, 10'h041, 3'b110, 0, 1);
        step(); cyc("rr t7", 0, 0,0,0,0, 0, 10'h0,   3'b110, 0, 1);
        step(); cyc("rr t8", 0, 0,0,0,1, 0, 10'h0,   3'b000, 0, 0);
        a_base = 10'h030; a_req = 1'b1; m_req = 1'b1;
        step(); cyc("rr t9", 0, 1,0,0,0, 1, 10'h030, 3'b000, 0, 1);
        a_req = 1'b0; m_req = 1'b0;
        step(); cyc("rr t10", 0, 0,0,0,0, 1, 10'h031, 3'b001, 0, 1);
        step(); cyc("rr t11", 0, 0,0,0,0, 0, 10'h0,   3'b001, 0, 1);
        step(); cyc("rr t12", 0, 0,0,1,0, 0, 10'h0,   3'b000, 0, 0);
        idle(3);

        // A-side pos burst, len 4
        a_dir = 2'b01; a_base = 10'h010; a_len = 8'd4; a_lk0 = 1'b0; a_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) a_req = 1'b0;
            cyc($sformatf("pos t%0d", k), 0, k == 1, 0, k == 6, 0, k <= 4,
                10'h010 + 10'(k - 1), (k >= 2 && k <= 5) ? 3'b001 : 3'b000, 0, k <= 5);
        end
        idle(2);

        // M-side new mode, l_k_0 = 1 then 0
        for (int r = 0; r < 2; r++) begin
            m_dir = 2'b11; m_base = 10'h100; m_len = 8'd3; m_lk0 = (r == 0); m_req = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                step();
                if (k == 1) m_req = 1'b0;
                cyc($sformatf("new%0d t%0d", r, k), 0, 0, k == 1, 0, k == 5, k <= 3,
                    10'h100 + 10'(k - 1), (k >= 2 && k <= 4) ? 3'b111 : 3'b000,
                    (r == 0) && (k >= 2 && k <= 4), k <= 4);
            end
            idle(2);
        end

        // Zero-length burst
        a_dir = 2'b01; a_base = 10'h1AB; a_len = 8'd0; a_req = 1'b1;
        step(); cyc("len0 t1", 0, 1,0,0,0, 0, 10'h0, 3'b000, 0, 1); a_req = 1'b0;
        step(); cyc("len0 t2", 0, 0,0,1,0, 0, 10'h0, 3'b000, 0, 0);
        step(); cyc("len0 t3", 0, 0,0,0,0, 0, 10'h0, 3'b000, 0, 0);
        idle(2);

        // RD_LAT = 2 with address wrap
        b_dir = 2'b10; b_base = 10'h3FE; b_len = 8'd4; b_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) b_req = 1'b0;
            cyc($sformatf("wrap t%0d", k), 1, k == 1, 0, k == 7, 0, k <= 4,
                10'h3FE + 10'(k - 1), (k >= 3 && k <= 6) ? 3'b010 : 3'b000, 0, k <= 6);
        end
        idle(2);

        // Reset mid-burst
        a_dir = 2'b01; a_base = 10'h050; a_len = 8'd8; a_req = 1'b1;
        step(); a_req = 1'b0;
        step(); step();
        cyc("mid pre", 0, 0,0,0,0, 1, 10'h052, 3'b001, 0, 1);
        sys_rst = 1'b1;
        #1;
        cyc("mid rst", 0, 0,0,0,0, 0, 10'h0, 3'b000, 0, 0);
        chk("mid rst addr", addr1, 10'h0);
        step(); step();
        sys_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("nodone t%0d", k), {a_done1, m_done1, ena1}, 3'b000);
        end

        // After reset the pointer is back at M, so A wins the tie
        a_dir = 2'b01; a_base = 10'h200; a_len = 8'd1; a_req = 1'b1;
        m_dir = 2'b10; m_base = 10'h077; m_len = 8'd1; m_lk0 = 1'b0; m_req = 1'b1;
        step(); cyc("post t1", 0, 1,0,0,0, 1, 10'h200, 3'b000, 0, 1); a_req = 1'b0;
        step(); cyc("post t2", 0, 0,0,0,0, 0, 10'h0,   3'b001, 0, 1);
        step(); cyc("post t3", 0, 0,0,1,0, 0, 10'h0,   3'b000, 0, 0);
        step(); cyc("post t4", 0, 0,1,0,0, 1, 10'h077, 3'b000, 0, 1); m_req = 1'b0;
        step(); cyc("post t5", 0, 0,0,0,0, 0, 10'h0,   3'b110, 0, 1);
        step(); cyc("post t6", 0, 0,0,0,1, 0, 10'h0,   3'b000, 0, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
